// File: rtl/som_pkg.sv
// Shared definitions for the tone-generator arbiter: state codes, note codes
// and the timing-counter width helper.
package som_pkg;

    localparam int unsigned NOTE_W = 4;

    localparam logic [NOTE_W-1:0] NOTA_SILENCIO = '0;
    localparam logic [NOTE_W-1:0] CLICK_NOTE    = 4'hF;

    typedef enum logic [2:0] {
        StOcioso   = 3'd0,
        StSilencio = 3'd1,
        StTocaMem  = 3'd2,
        StTocaJog  = 3'd3,
        StClick    = 3'd4
    } estado_t;

    // Width needed to hold (largest duration - 1); never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/contador_duracao.sv
// Loadable duration counter shared by hold, click and gap timing.
// Counts up saturating at 'limite', or down saturating at zero; 'fim' flags
// the terminal value for the current direction.
module contador_duracao #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carga,
    input  logic [Width-1:0] valor_carga,
    input  logic             habilita,
    input  logic             conta_cima,
    input  logic [Width-1:0] limite,
    output logic             fim
);

    logic [Width-1:0] cnt_q;

    // Count register: load has priority over counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (carga) begin
            cnt_q <= valor_carga;
        end else if (habilita) begin
            if (conta_cima) begin
                if (cnt_q != limite) cnt_q <= cnt_q + Width'(1);
            end else begin
                if (cnt_q != '0) cnt_q <= cnt_q - Width'(1);
            end
        end
    end

    // Terminal flag depends on the counting direction.
    always_comb begin
        fim = conta_cima ? (cnt_q == limite) : (cnt_q == '0);
    end

endmodule

// File: rtl/arbitro_saida_som.sv
// Arbiter for the shared tone generator: grants playback, player or metronome
// click one at a time, enforcing a minimum note hold and a silence gap.
// Optional build macro JOGADOR_PREEMPTA_EN: a player request cuts a playback
// note immediately instead of waiting for the minimum hold.
module arbitro_saida_som
    import som_pkg::*;
#(
    parameter int unsigned CLICK_CYCLES = 50000,
    parameter int unsigned MIN_HOLD     = 5000000,
    parameter int unsigned GAP_CYCLES   = 500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              metro_en,
    input  logic              tick_metro,
    input  logic              req_mem,
    input  logic [NOTE_W-1:0] nota_mem,
    input  logic              req_jog,
    input  logic [NOTE_W-1:0] nota_jog,
    output logic              gnt_mem,
    output logic              gnt_jog,
    output logic [NOTE_W-1:0] nota_saida,
    output logic              som_ativo,
    output logic              click,
    output logic              ocupado,
    output logic [2:0]        db_estado
);

    localparam int unsigned CntW = cnt_width(MIN_HOLD, CLICK_CYCLES, GAP_CYCLES);

    localparam logic [CntW-1:0] HoldMax  = CntW'(MIN_HOLD - 1);
    localparam logic [CntW-1:0] ClickIni = CntW'(CLICK_CYCLES - 1);
    localparam logic [CntW-1:0] GapIni   = CntW'(GAP_CYCLES - 1);

    estado_t           st_q, st_d;
    logic              click_pend_q, click_pend_d;
    logic [NOTE_W-1:0] nota_q, nota_d;

    logic            cnt_carga;
    logic [CntW-1:0] cnt_valor;
    logic            cnt_hab;
    logic            cnt_cima;
    logic            cnt_fim;
    logic            tick_ok;
    logic            entra_click;
    logic            libera;

    // Hold timing counts up from the grant; click and gap count down.
    assign cnt_cima = (st_q == StTocaMem) || (st_q == StTocaJog);
    assign tick_ok  = tick_metro & metro_en;

    contador_duracao #(
        .Width(CntW)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .carga      (cnt_carga),
        .valor_carga(cnt_valor),
        .habilita   (cnt_hab),
        .conta_cima (cnt_cima),
        .limite     (HoldMax),
        .fim        (cnt_fim)
    );

    // Next-state, counter control and note latch.
    always_comb begin
        st_d        = st_q;
        nota_d      = nota_q;
        cnt_carga   = 1'b0;
        cnt_valor   = '0;
        cnt_hab     = 1'b0;
        entra_click = 1'b0;
        libera      = 1'b0;
        case (st_q)
            StOcioso: begin
                // A tick arriving this cycle counts, so a click beats a same-cycle request.
                if (click_pend_q || tick_ok) begin
                    st_d        = StClick;
                    cnt_carga   = 1'b1;
                    cnt_valor   = ClickIni;
                    nota_d      = CLICK_NOTE;
                    entra_click = 1'b1;
                end else if (req_jog) begin
                    st_d      = StTocaJog;
                    cnt_carga = 1'b1;
                    nota_d    = nota_jog;
                end else if (req_mem) begin
                    st_d      = StTocaMem;
                    cnt_carga = 1'b1;
                    nota_d    = nota_mem;
                end
            end
            StTocaMem: begin
                cnt_hab = 1'b1;
`ifdef JOGADOR_PREEMPTA_EN
                libera = req_jog || (cnt_fim && !req_mem);
`else
                libera = cnt_fim && (!req_mem || req_jog);
`endif
                if (libera) begin
                    st_d      = StSilencio;
                    cnt_carga = 1'b1;
                    cnt_valor = GapIni;
                end
            end
            StTocaJog: begin
                cnt_hab = 1'b1;
                if (cnt_fim && !req_jog) begin
                    st_d      = StSilencio;
                    cnt_carga = 1'b1;
                    cnt_valor = GapIni;
                end
            end
            StClick: begin
                cnt_hab = 1'b1;
                if (cnt_fim) begin
                    st_d      = StSilencio;
                    cnt_carga = 1'b1;
                    cnt_valor = GapIni;
                end
            end
            StSilencio: begin
                cnt_hab = 1'b1;
                if (cnt_fim) st_d = StOcioso;
            end
            default: st_d = StOcioso;
        endcase
        // Ticks collapse into one pending click; disabling the metronome drops it.
        click_pend_d = metro_en && (click_pend_q || tick_metro) && !entra_click;
    end

    // State, pending-click flag and latched note.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q         <= StOcioso;
            click_pend_q <= 1'b0;
            nota_q       <= NOTA_SILENCIO;
        end else begin
            st_q         <= st_d;
            click_pend_q <= click_pend_d;
            nota_q       <= nota_d;
        end
    end

    // Moore outputs decoded from state and latched note only.
    always_comb begin
        gnt_mem    = 1'b0;
        gnt_jog    = 1'b0;
        som_ativo  = 1'b0;
        click      = 1'b0;
        ocupado    = 1'b1;
        nota_saida = NOTA_SILENCIO;
        case (st_q)
            StOcioso:   ocupado = 1'b0;
            StSilencio: ocupado = 1'b1;
            StTocaMem: begin
                gnt_mem    = 1'b1;
                som_ativo  = 1'b1;
                nota_saida = nota_q;
            end
            StTocaJog: begin
                gnt_jog    = 1'b1;
                som_ativo  = 1'b1;
                nota_saida = nota_q;
            end
            StClick: begin
                click      = 1'b1;
                som_ativo  = 1'b1;
                nota_saida = CLICK_NOTE;
            end
            default: ocupado = 1'b0;
        endcase
    end

    assign db_estado = st_q;

endmodule

// File: tb/tb_arbitro_saida_som.sv
// Self-checking bench for arbitro_saida_som: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the arbitration rules.
module tb_arbitro_saida_som;

    localparam int unsigned CLICK_CYCLES = 4;
    localparam int unsigned MIN_HOLD     = 8;
    localparam int unsigned GAP_CYCLES   = 3;

    localparam int MD_IDLE  = 0;
    localparam int MD_GAP   = 1;
    localparam int MD_MEM   = 2;
    localparam int MD_JOG   = 3;
    localparam int MD_CLICK = 4;

    typedef struct packed {
        int         mode;
        logic [3:0] note;
        int         sounded;
        int         left;
        logic       pend;
    } mdl_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       metro_en = 1'b0;
    logic       tick_metro = 1'b0;
    logic       req_mem = 1'b0;
    logic       req_jog = 1'b0;
    logic [3:0] nota_mem = 4'd0;
    logic [3:0] nota_jog = 4'd0;
    logic       gnt_mem, gnt_jog, som_ativo, click, ocupado;
    logic [3:0] nota_saida;
    logic [2:0] db_estado;
    logic [11:0] dut_out;

    int   n_checks = 0;
    int   n_fail = 0;
    mdl_t m;

    arbitro_saida_som #(
        .CLICK_CYCLES(CLICK_CYCLES),
        .MIN_HOLD    (MIN_HOLD),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .metro_en  (metro_en),
        .tick_metro(tick_metro),
        .req_mem   (req_mem),
        .nota_mem  (nota_mem),
        .req_jog   (req_jog),
        .nota_jog  (nota_jog),
        .gnt_mem   (gnt_mem),
        .gnt_jog   (gnt_jog),
        .nota_saida(nota_saida),
        .som_ativo (som_ativo),
        .click     (click),
        .ocupado   (ocupado),
        .db_estado (db_estado)
    );

    assign dut_out = {gnt_mem, gnt_jog, som_ativo, click, ocupado, db_estado, nota_saida};

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock of the arbitration rules, in terms of activity and elapsed time.
    function automatic mdl_t model_step(input mdl_t c, input logic rm, input logic rj,
                                        input logic [3:0] nm, input logic [3:0] nj,
                                        input logic tk, input logic me);
        mdl_t n         = c;
        logic tick_ok   = tk && me;
        logic go_click  = 1'b0;
        logic want_off  = 1'b0;
        logic may_leave = 1'b0;
        case (c.mode)
            MD_IDLE: begin
                if (c.pend || tick_ok) begin
                    n.mode   = MD_CLICK;
                    n.left   = CLICK_CYCLES;
                    go_click = 1'b1;
                end else if (rj) begin
                    n.mode = MD_JOG; n.note = nj; n.sounded = 1;
                end else if (rm) begin
                    n.mode = MD_MEM; n.note = nm; n.sounded = 1;
                end
            end
            MD_MEM, MD_JOG: begin
                want_off  = (c.mode == MD_MEM) ? (!rm || rj) : !rj;
                may_leave = (c.sounded >= MIN_HOLD);
`ifdef JOGADOR_PREEMPTA_EN
                if (c.mode == MD_MEM && rj) may_leave = 1'b1;
`endif
                if (want_off && may_leave) begin
                    n.mode = MD_GAP; n.left = GAP_CYCLES;
                end else begin
                    n.sounded = c.sounded + 1;
                end
            end
            MD_CLICK: begin
                if (c.left == 1) begin
                    n.mode = MD_GAP; n.left = GAP_CYCLES;
                end else begin
                    n.left = c.left - 1;
                end
            end
            default: begin
                if (c.left == 1) n.mode = MD_IDLE;
                else n.left = c.left - 1;
            end
        endcase
        if (!me || go_click) n.pend = 1'b0;
        else if (tick_ok) n.pend = 1'b1;
        return n;
    endfunction

    function automatic logic [11:0] expect_out(input mdl_t c);
        logic       gm = 1'b0, gj = 1'b0, so = 1'b0, ck = 1'b0, oc = 1'b0;
        logic [2:0] db = 3'd0;
        logic [3:0] nt = 4'd0;
        case (c.mode)
            MD_GAP:   begin oc = 1'b1; db = 3'd1; end
            MD_MEM:   begin gm = 1'b1; so = 1'b1; oc = 1'b1; db = 3'd2; nt = c.note; end
            MD_JOG:   begin gj = 1'b1; so = 1'b1; oc = 1'b1; db = 3'd3; nt = c.note; end
            MD_CLICK: begin ck = 1'b1; so = 1'b1; oc = 1'b1; db = 3'd4; nt = 4'hF; end
            default:  ;
        endcase
        return {gm, gj, so, ck, oc, db, nt};
    endfunction

    // Reference model advances on the same edges as the DUT.
    always @(posedge clock or posedge reset) begin
        if (reset) m <= '0;
        else m <= model_step(m, req_mem, req_jog, nota_mem, nota_jog, tick_metro, metro_en);
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("cycle_outputs", {20'd0, dut_out}, {20'd0, expect_out(m)});
            check("grant_overlap", {31'd0, gnt_mem & gnt_jog}, 32'd0);
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clock);
            if (db_estado == 3'd0) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: state 0x%0h, required 0x0 within 300 cycles", db_estado);
        end
    endtask

    initial begin
        int c_note, c_sil, c_clk, c_gm, first_jog;

        // Reset state
        #12;
        check("reset_outputs", {20'd0, dut_out}, 32'd0);
        check("reset_db", {29'd0, db_estado}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        metro_en = 1'b1;

        // 1: playback held 20 cycles
        wait_idle();
        req_mem = 1'b1; nota_mem = 4'd5;
        c_note = 0; c_sil = 0;
        repeat (20) begin
            @(negedge clock);
            if (gnt_mem && som_ativo && nota_saida == 4'd5) c_note++;
        end
        req_mem = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (db_estado == 3'd1 && !som_ativo && nota_saida == 4'd0) c_sil++;
        end
        @(negedge clock);
        check("s1_note_cycles", c_note, 20);
        check("s1_gap_cycles", c_sil, 3);
        check("s1_back_idle", {29'd0, db_estado}, 32'd0);

        // 2: short player press, note change mid-note ignored
        wait_idle();
        req_jog = 1'b1; nota_jog = 4'd9;
        c_note = 0; c_sil = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (gnt_jog && nota_saida == 4'd9) c_note++;
            if (db_estado == 3'd1) c_sil++;
            if (i == 1) nota_jog = 4'd3;
            if (i == 2) req_jog = 1'b0;
        end
        check("s2_min_hold", c_note, 8);
        check("s2_gap_cycles", c_sil, 3);

        // 3: tick and player request together: click first
        wait_idle();
        tick_metro = 1'b1; req_jog = 1'b1; nota_jog = 4'd6;
        c_clk = 0; c_sil = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            tick_metro = 1'b0;
            if (click && som_ativo && nota_saida == 4'hF) c_clk++;
            if (db_estado == 3'd1) c_sil++;
        end
        check("s3_click_cycles", c_clk, 4);
        check("s3_gap_cycles", c_sil, 3);
        check("s3_jog_after", {31'd0, gnt_jog}, 32'd1);
        check("s3_jog_note", {28'd0, nota_saida}, 32'd6);
        req_jog = 1'b0;

        // 4: three ticks during a note collapse into one click; none when disabled
        for (int pass = 0; pass < 2; pass++) begin
            wait_idle();
            metro_en = (pass == 0);
            req_mem = 1'b1; nota_mem = 4'd2;
            c_clk = 0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clock);
                tick_metro = (i == 3 || i == 5 || i == 7);
                if (i == 10) req_mem = 1'b0;
                if (click) c_clk++;
            end
            tick_metro = 1'b0;
            check(pass == 0 ? "s4_one_click" : "s4_no_click", c_clk, pass == 0 ? 4 : 0);
        end
        metro_en = 1'b1;

        // 5: player request during playback
        wait_idle();
        req_mem = 1'b1; nota_mem = 4'd7;
        c_gm = 0; first_jog = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 3) req_jog = 1'b1;
            if (gnt_mem) c_gm++;
            if (gnt_jog && first_jog == 0) first_jog = i;
        end
`ifdef JOGADOR_PREEMPTA_EN
        check("s5_mem_cycles", c_gm, 3);
        check("s5_jog_start", first_jog, 8);
`else
        check("s5_mem_cycles", c_gm, 8);
        check("s5_jog_start", first_jog, 13);
`endif
        req_mem = 1'b0; req_jog = 1'b0;

        // 6: asynchronous reset mid-click with a click pending
        wait_idle();
        tick_metro = 1'b1;
        @(negedge clock);
        tick_metro = 1'b0;
        @(negedge clock);
        tick_metro = 1'b1;
        @(negedge clock);
        tick_metro = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("s6_reset_outputs", {20'd0, dut_out}, 32'd0);
        check("s6_reset_db", {29'd0, db_estado}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        c_clk = 0;
        repeat (12) begin
            @(negedge clock);
            if (click) c_clk++;
        end
        check("s6_pending_cleared", c_clk, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 15) == 0) req_mem = ~req_mem;
            if ($urandom_range(0, 11) == 0) req_jog = ~req_jog;
            if ($urandom_range(0, 199) == 0) metro_en = ~metro_en;
            nota_mem   = 4'($urandom_range(0, 15));
            nota_jog   = 4'($urandom_range(0, 15));
            tick_metro = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_saida_som.md
Name: arbitro_saida_som

Overview:
- Sequences the single shared tone generator (buzzer/PWM note output) among three sources:
  - memory playback during the "show sequence" phase,
  - live player key presses,
  - metronome clicks.
- Grants one source at a time and enforces a minimum note duration and an inter-note silence gap.
- Drives the note code and enable into the tone generator.
- Sits between the game control units, the metronome and the audio datapath.

Parameters:
- NOTE_W, 4, width of note code; code 0 = silence.
- CLICK_NOTE, 4'hF, note code emitted for a metronome click.
- CLICK_CYCLES, 50000, click duration in clock cycles (1 ms @ 50 MHz).
- MIN_HOLD, 5000000, minimum cycles a granted note sounds (100 ms).
- GAP_CYCLES, 500000, silence cycles between consecutive grants (10 ms).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- metro_en  in  1  metronome enabled; when low, ticks are ignored and any pending click is cleared
- tick_metro  in  1  one-cycle pulse, one beat
- req_mem  in  1  playback request (level)
- nota_mem  in  NOTE_W  playback note code
- req_jog  in  1  player request (level, key held)
- nota_jog  in  NOTE_W  player note code
- gnt_mem  out  1  playback source owns generator
- gnt_jog  out  1  player source owns generator
- nota_saida  out  NOTE_W  note code to tone generator
- som_ativo  out  1  tone generator enable
- click  out  1  high while a click sounds
- ocupado  out  1  high in any state other than OCIOSO
- db_estado  out  3  current state code

Behaviour:
- Single Moore FSM. All outputs are decoded from the state and registered data only.
- States:
  - OCIOSO = 0
  - SILENCIO = 1
  - TOCA_MEM = 2
  - TOCA_JOG = 3
  - CLICK = 4
- Reset (asynchronous, any time, including mid-note):
  - state OCIOSO; cnt = 0; click_pend = 0; nota_reg = 0.
  - All outputs 0: gnt_*, som_ativo, click, ocupado, nota_saida.
- click_pend:
  - Set on tick_metro when metro_en = 1.
  - Cleared on entry to CLICK, or whenever metro_en = 0.
  - Multiple ticks while pending collapse into one click.
- OCIOSO grant priority (evaluated each cycle):
  1. click_pend → CLICK; cnt loaded with CLICK_CYCLES-1; nota_reg = CLICK_NOTE.
  2. req_jog → TOCA_JOG; nota_reg = nota_jog; cnt = 0.
  3. req_mem → TOCA_MEM; nota_reg = nota_mem; cnt = 0.
  - Grant is visible the cycle after the request is sampled (latency 1).
- TOCA_x:
  - gnt_x = 1; som_ativo = 1; nota_saida = nota_reg.
  - The note is latched at grant; input note changes are ignored until the next grant.
  - cnt saturates at MIN_HOLD-1.
  - Exit to SILENCIO when req_x = 0 and cnt = MIN_HOLD-1. A request dropped early still sounds MIN_HOLD cycles in total.
  - Preemption, in TOCA_MEM only: if req_jog = 1 and cnt = MIN_HOLD-1, go to SILENCIO even if req_mem is still high.
  - Clicks never preempt; they wait in click_pend.
- CLICK:
  - click = 1; som_ativo = 1; nota_saida = CLICK_NOTE.
  - cnt counts down; at 0 go to SILENCIO.
- SILENCIO:
  - som_ativo = 0; nota_saida = 0.
  - Lasts exactly GAP_CYCLES cycles, then OCIOSO.
- gnt_mem and gnt_jog are never simultaneously high.
- Simultaneous tick and request in OCIOSO: the click wins; the request is served after click + gap if still high.
- Counter width: $clog2 of the largest of MIN_HOLD, CLICK_CYCLES and GAP_CYCLES.
- Unused state codes return to OCIOSO.

Optional Feature:
- Macro: JOGADOR_PREEMPTA_EN.
- Defined: in TOCA_MEM, req_jog = 1 forces SILENCIO on the next cycle regardless of cnt. The player's key response is immediate.
- Undefined: preemption waits for MIN_HOLD, as described above.

Decomposition:
- Shared package `som_pkg`:
  - state encodings;
  - NOTE_W;
  - NOTA_SILENCIO = 0;
  - CLICK_NOTE.
- One sub-module `contador_duracao`:
  - Loadable down/up counter with load, enable, saturate and done flag.
  - Instantiated once, shared by the hold, click and gap timing.

Test Plan:
- (Use MIN_HOLD = 8, GAP_CYCLES = 3, CLICK_CYCLES = 4 for all scenarios.)
1. req_mem = 1, nota_mem = 5 held 20 cycles → gnt_mem rises 1 cycle later, nota_saida = 5 for 20 cycles, then 3 cycles of silence, then OCIOSO.
2. req_jog pulsed 2 cycles with nota_jog = 9 → note 9 sounds exactly 8 cycles, then 3 silence cycles; nota_jog changed mid-note is ignored.
3. tick_metro and req_jog in the same cycle with metro_en = 1 → click = 1 for 4 cycles with nota_saida = 4'hF, 3 silence cycles, then gnt_jog.
4. Three ticks during a TOCA_MEM note → exactly one click after the note; with metro_en = 0 → no click.
5. TOCA_MEM active, req_jog asserted at cnt = 2 → switch at cnt = 7 (macro off) or the next cycle (macro on); gnt_mem and gnt_jog never overlap.
6. Reset asserted mid-click → all outputs 0 immediately (asynchronous), db_estado = 0, pending click cleared.
